// File: rtl/scc_pkg.sv
// Shared fetch-path definitions: address/instruction widths, reset PC,
// sequential fetch stride and the FIFO entry layout.
package scc_pkg;

    localparam int SCC_ADDR_W  = 32;
    localparam int SCC_INSTR_W = 32;

    localparam logic [SCC_ADDR_W-1:0] SCC_RESET_PC  = 32'h0000_0000;
    localparam logic [SCC_ADDR_W-1:0] SCC_ADDR_STEP = 32'd4;

    typedef struct packed {
        logic [SCC_ADDR_W-1:0]  pc;
        logic [SCC_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Bundles the instruction-memory port, the IF-stage handshake and the redirect
// request; master is the fetch buffer side, slave is the memory/IF side.
interface fetch_buffer_if;
    import scc_pkg::*;

    logic [SCC_ADDR_W-1:0]  in_mem_addr;
    logic                   in_mem_en;
    logic [SCC_INSTR_W-1:0] in_mem;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [SCC_INSTR_W-1:0] instruction;
    logic [SCC_ADDR_W-1:0]  instr_pc;
    logic                   redirect;
    logic [SCC_ADDR_W-1:0]  redirect_pc;

    modport master (
        output in_mem_addr, in_mem_en, instr_valid, instruction, instr_pc,
        input  in_mem, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  in_mem_addr, in_mem_en, instr_valid, instruction, instr_pc,
        output in_mem, instr_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_buffer_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} entries; flush (and reset) take
// priority over push and pop. The head reads as zero whenever the FIFO is empty.
module fetch_fifo
    import scc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               pop_en;
    logic               clear;

    assign clear  = reset || flush;
    assign pop_en = pop && (count != '0);

    // Pointers are log2(DEPTH) bits wide, so they wrap without explicit compare.
    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: issues sequential reads to a one-cycle-latency
// instruction memory and queues the returned words for the IF stage.
module fetch_buffer
    import scc_pkg::*;
#(
    parameter int                    DEPTH     = 4,
    parameter logic [SCC_ADDR_W-1:0] RESET_PC  = SCC_RESET_PC,
    parameter logic [SCC_ADDR_W-1:0] ADDR_STEP = SCC_ADDR_STEP
) (
    input  logic           clk,
    input  logic           reset,
    fetch_buffer_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [SCC_ADDR_W-1:0] fetch_pc;
    logic [SCC_ADDR_W-1:0] ret_pc;
    logic                  inflight;
    logic [CNT_W-1:0]      count;
    logic [SUM_W-1:0]      credit_used;
    logic                  deq;
    logic                  issue;
    fetch_entry_t          head;
    fetch_entry_t          ret_entry;

    assign deq = bus.instr_valid && bus.instr_ready;

    // A slot is reserved for every in-flight read, so a returning word always fits.
    assign credit_used = {1'b0, count} + SUM_W'(inflight) - SUM_W'(deq);
    assign issue       = !reset && !bus.redirect && (credit_used < SUM_W'(DEPTH));

    assign bus.in_mem_en   = issue;
    assign bus.in_mem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            ret_pc   <= '0;
            inflight <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_STEP;
                ret_pc   <= fetch_pc;
            end
        end
    end

    assign ret_entry = {ret_pc, bus.in_mem};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (inflight && !bus.redirect),
        .push_data (ret_entry),
        .pop       (deq && !bus.redirect),
        .head      (head),
        .count     (count)
    );

    assign bus.instr_valid = !reset && (count != '0);
    assign bus.instruction = head.instr;
    assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus a long random
// run, with IF-side outputs checked against an expected-PC scoreboard.
module tb_fetch_buffer;
    import scc_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_buffer_if bus ();

    fetch_buffer #(
        .DEPTH     (DEPTH),
        .RESET_PC  (32'h0000_0000),
        .ADDR_STEP (32'd4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int          checks       = 0;
    int          errors       = 0;
    int          outstanding  = 0;
    int          issues_seen  = 0;
    int          accepted     = 0;
    int          issue_base   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] next_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    // Synchronous instruction memory: word appears the cycle after the request.
    always @(posedge clk) begin
        bus.in_mem <= bus.in_mem_en ? mem_word(bus.in_mem_addr) : $urandom;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic restart_model(input logic [31:0] start);
        exp_q.delete();
        next_pc = start;
    endtask

    task automatic refill_model();
        while (exp_q.size() < 16) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc, input logic rst);
        @(posedge clk);
        #1;
        reset           = rst;
        bus.instr_ready = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = redir ? rpc : $urandom;
        if (rst) begin
            restart_model(32'h0000_0000);
        end else if (redir) begin
            restart_model(rpc);
        end
        refill_model();
    endtask

    // Monitor: every accepted handshake must be the next PC of the current stream.
    always @(negedge clk) begin
        if (bus.in_mem_en) begin
            issues_seen++;
        end
        if (reset || bus.redirect) begin
            outstanding = 0;
        end else begin
            if (bus.instr_valid && bus.instr_ready) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_empty actual=%h expected=<none>", bus.instr_pc);
                end else begin
                    automatic logic [31:0] exp_pc = exp_q.pop_front();
                    checkOutput("sb_pc", bus.instr_pc, exp_pc);
                    checkOutput("sb_instr", bus.instruction, mem_word(exp_pc));
                end
            end
            outstanding = outstanding + int'(bus.in_mem_en) - int'(bus.instr_valid && bus.instr_ready);
            checkOutput("occupancy_le_depth", 32'(outstanding <= DEPTH), 32'd1);
        end
    end

    initial begin
        reset           = 1'b1;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        restart_model(32'h0000_0000);
        refill_model();

        // Reset, then free-running stream.
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("reset_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("reset_en", 32'(bus.in_mem_en), 32'd0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
            @(negedge clk);
            if (k == 0) begin
                checkOutput("empty_instruction", bus.instruction, 32'd0);
                checkOutput("empty_pc", bus.instr_pc, 32'd0);
            end
            checkOutput("stream_en", 32'(bus.in_mem_en), 32'd1);
            checkOutput("stream_addr", bus.in_mem_addr, 32'(4 * k));
            checkOutput("stream_valid", 32'(bus.instr_valid), 32'(k >= 2));
        end

        // Stall IF: exactly DEPTH reads go out, then drain with no bubble.
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        issue_base = issues_seen;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
        end
        @(negedge clk);
        checkOutput("stall_issue_count", 32'(issues_seen - issue_base), 32'(DEPTH));
        checkOutput("stall_en", 32'(bus.in_mem_en), 32'd0);
        checkOutput("stall_valid", 32'(bus.instr_valid), 32'd1);
        checkOutput("stall_head_pc", bus.instr_pc, 32'd0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
            @(negedge clk);
            checkOutput("drain_no_gap", 32'(bus.instr_valid), 32'd1);
        end

        // Redirect with pc 8 in flight and two entries queued.
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        @(negedge clk);
        checkOutput("redir_en", 32'(bus.in_mem_en), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("redir_next_en", 32'(bus.in_mem_en), 32'd1);
        checkOutput("redir_next_addr", bus.in_mem_addr, 32'h0000_0100);
        checkOutput("redir_next_valid", 32'(bus.instr_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("redir_n1_valid", 32'(bus.instr_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("redir_n2_valid", 32'(bus.instr_valid), 32'd1);
        checkOutput("redir_n2_pc", bus.instr_pc, 32'h0000_0100);

        // Redirect coinciding with a dequeue and a returning word.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        @(negedge clk);
        checkOutput("redir_deq_valid", 32'(bus.instr_valid), 32'd1);
        checkOutput("redir_deq_en", 32'(bus.in_mem_en), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("redir_deq_empty", 32'(bus.instr_valid), 32'd0);
        checkOutput("redir_deq_addr", bus.in_mem_addr, 32'h0000_0200);
        checkOutput("redir_deq_issue", 32'(bus.in_mem_en), 32'd1);

        // Reset with a full FIFO.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
        end
        @(negedge clk);
        checkOutput("full_valid", 32'(bus.instr_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("midreset_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("midreset_en", 32'(bus.in_mem_en), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("postreset_en", 32'(bus.in_mem_en), 32'd1);
        checkOutput("postreset_addr", bus.in_mem_addr, 32'h0000_0000);
        checkOutput("postreset_valid", 32'(bus.instr_valid), 32'd0);

        // Random backpressure, redirects (some near the top of the address space) and resets.
        for (int k = 0; k < 2000; k++) begin
            automatic logic        rdy   = ($urandom_range(0, 99) < 65);
            automatic logic        redir = ($urandom_range(0, 99) < 3);
            automatic logic        rst   = ($urandom_range(0, 499) == 0);
            automatic logic [31:0] rpc   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : $urandom;
            applyStimulus(rdy, redir, rpc, rst);
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
        end
        @(negedge clk);
        checkOutput("random_progress", 32'(accepted > 500), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
